// File: rtl/rv_pkg.sv
// Shared RV core definitions: architectural widths, scalar typedefs and
// the write-back priority encoding.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LSU_PRI = 1'b1
  } wb_pri_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per destination register, set at
// issue and cleared on the RF write edge, with the RAW/WAW stall compare.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_i,
  input  logic [ADDR_W-1:0]     issue_addr_i,
  input  logic [ADDR_W-1:0]     rs1_addr_i,
  input  logic [ADDR_W-1:0]     rs2_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_W-1:0]     clr_addr_i,
  output logic                  stall_o,
  output logic [2**ADDR_W-1:0]  busy_o
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic            rs1_hit, rs2_hit, rd_hit;
  logic            set_en;

  // No bypass from the write being committed this cycle: the RF only holds
  // the new value after this edge, so the bit must still stall until then.
  always_comb begin
    rs1_hit = (rs1_addr_i != '0) && busy_q[rs1_addr_i];
    rs2_hit = (rs2_addr_i != '0) && busy_q[rs2_addr_i];
    rd_hit  = issue_i && (issue_addr_i != '0) && busy_q[issue_addr_i];
    stall_o = rs1_hit | rs2_hit | rd_hit;
    set_en  = issue_i && (issue_addr_i != '0) && !stall_o;
  end

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en) busy_d[issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the RF single write port: ALU/LSU arbitration with
// LSU starvation guard, registered RF drive and the hazard scoreboard.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_W-1:0]     alu_addr_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_W-1:0]     lsu_addr_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  input  logic                  issue_i,
  input  logic [ADDR_W-1:0]     issue_addr_i,
  input  logic [ADDR_W-1:0]     rs1_addr_i,
  input  logic [ADDR_W-1:0]     rs2_addr_i,
  output logic                  stall_o,
  output logic                  rf_we_o,
  output logic [ADDR_W-1:0]     rf_addr_o,
  output logic [DATA_W-1:0]     rf_wd_o,
  output logic [2**ADDR_W-1:0]  busy_o
);

  localparam int              WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

  wb_pri_e           pri;
  logic              alu_hs, lsu_hs, any_hs;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

  // Each ready depends only on the opposing valid and the mode, so the two
  // handshakes are mutually exclusive and there is no ready-to-ready loop.
  always_comb begin
    pri         = (wait_q == WAIT_MAX) ? LSU_PRI : ALU_PRI;
    alu_ready_o = (pri == ALU_PRI) ? 1'b1 : !lsu_valid_i;
    lsu_ready_o = (pri == ALU_PRI) ? !alu_valid_i : 1'b1;
    alu_hs      = alu_valid_i && alu_ready_o;
    lsu_hs      = lsu_valid_i && lsu_ready_o;
    any_hs      = alu_hs || lsu_hs;
    win_addr    = lsu_hs ? lsu_addr_i : alu_addr_i;
    win_data    = lsu_hs ? lsu_data_i : alu_data_i;
  end

  always_comb begin
    wait_d = wait_q;
    if (!lsu_valid_i || lsu_hs) wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
  end

  // x0 writes are consumed but never reach the RF; the data register keeps
  // its previous value so WD3 does not toggle for a discarded write.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_wd_d   = rf_wd_q;
    if (any_hs) begin
      rf_addr_d = win_addr;
      if (win_addr != '0) begin
        rf_we_d = 1'b1;
        rf_wd_d = win_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wait_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_wd_q   <= '0;
    end else begin
      wait_q    <= wait_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_wd_q   <= rf_wd_d;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_wd_o   = rf_wd_q;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .clr_i        (rf_we_q),
    .clr_addr_i   (rf_addr_q),
    .stall_o      (stall_o),
    .busy_o       (busy_o)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_MAX = 4).
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alu_valid_i, lsu_valid_i, issue_i;
  logic        alu_ready_o, lsu_ready_o, stall_o, rf_we_o;
  logic [4:0]  alu_addr_i, lsu_addr_i, issue_addr_i, rs1_addr_i, rs2_addr_i, rf_addr_o;
  logic [31:0] alu_data_i, lsu_data_i, rf_wd_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .issue_i(issue_i), .issue_addr_i(issue_addr_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_wd_o(rf_wd_o), .busy_o(busy_o)
  );

  // Advance past the next rising edge; registered outputs are settled here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; lsu_valid_i = 0; issue_i = 0;
    alu_addr_i = 0; lsu_addr_i = 0; issue_addr_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
    alu_data_i = 0; lsu_data_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 0;
    alu_valid_i = 1; alu_addr_i = 5; alu_data_i = 32'h1;
    tick(); tick();
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we actual=%0h required=0", rf_we_o); end
    n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL reset_busy actual=%0h required=0", busy_o); end
    n_checks++; if (rf_addr_o !== 5'd0 || rf_wd_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr_wd actual=%0h/%0h required=0/0", rf_addr_o, rf_wd_o); end
    reset_i = 1;
    tick();
    alu_valid_i = 0;
    n_checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd5 || rf_wd_o !== 32'h1) begin n_fail++; $display("FAIL first_write actual=%0h/%0h/%0h required=1/5/1", rf_we_o, rf_addr_o, rf_wd_o); end
  endtask

  task automatic test_single_alu();
    alu_valid_i = 1; alu_addr_i = 1; alu_data_i = 32'hDEADBEEF;
    #1;
    n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL alu_ready actual=%0h required=1", alu_ready_o); end
    tick();
    alu_valid_i = 0;
    n_checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd1 || rf_wd_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_write actual=%0h/%0h/%0h required=1/1/deadbeef", rf_we_o, rf_addr_o, rf_wd_o); end
    tick();
    n_checks++; if (rf_we_o !== 1'b0 || rf_wd_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_hold actual=%0h/%0h required=0/deadbeef", rf_we_o, rf_wd_o); end
  endtask

  task automatic test_contention();
    lsu_valid_i = 1; lsu_addr_i = 20; lsu_data_i = 32'h2020;
    alu_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      alu_addr_i = 5'(10 + i); alu_data_i = 32'hA0 + i;
      #1;
      n_checks++; if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL contend_alu_win%0d actual=%0h/%0h required=1/0", i, alu_ready_o, lsu_ready_o); end
      tick();
      n_checks++; if (rf_addr_o !== 5'(10 + i) || rf_wd_o !== 32'hA0 + i) begin n_fail++; $display("FAIL contend_alu_wr%0d actual=%0h/%0h required=%0h/%0h", i, rf_addr_o, rf_wd_o, 10 + i, 32'hA0 + i); end
    end
    alu_addr_i = 5'd15; alu_data_i = 32'hBB;
    #1;
    n_checks++; if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_lsu_win actual=%0h/%0h required=0/1", alu_ready_o, lsu_ready_o); end
    tick();
    n_checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd20 || rf_wd_o !== 32'h2020) begin n_fail++; $display("FAIL starve_lsu_wr actual=%0h/%0h/%0h required=1/14/2020", rf_we_o, rf_addr_o, rf_wd_o); end
    // Counter must be back at zero: contention now favours the ALU again.
    lsu_addr_i = 21;
    #1;
    n_checks++; if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL wait_cleared actual=%0h/%0h required=1/0", alu_ready_o, lsu_ready_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    lsu_valid_i = 1; lsu_addr_i = 0; lsu_data_i = 32'hFFFFFFFF;
    #1;
    n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready actual=%0h required=1", lsu_ready_o); end
    tick();
    lsu_valid_i = 0;
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we actual=%0h required=0", rf_we_o); end
    n_checks++; if (busy_o !== 32'h0 || rf_wd_o !== 32'h2020) begin n_fail++; $display("FAIL x0_busy_wd actual=%0h/%0h required=0/2020", busy_o, rf_wd_o); end
  endtask

  task automatic test_raw();
    issue_i = 1; issue_addr_i = 7;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall actual=%0h required=0", stall_o); end
    tick();
    issue_i = 0; rs1_addr_i = 7;
    #1;
    n_checks++; if (busy_o !== 32'h80 || stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_busy_stall actual=%0h/%0h required=80/1", busy_o, stall_o); end
    lsu_valid_i = 1; lsu_addr_i = 7; lsu_data_i = 32'h77;
    tick();
    lsu_valid_i = 0;
    n_checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd7 || stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_we_cycle actual=%0h/%0h/%0h required=1/7/1", rf_we_o, rf_addr_o, stall_o); end
    tick();
    n_checks++; if (stall_o !== 1'b0 || busy_o !== 32'h0) begin n_fail++; $display("FAIL raw_release actual=%0h/%0h required=0/0", stall_o, busy_o); end
    rs1_addr_i = 0;
  endtask

  task automatic test_collision();
    issue_i = 1; issue_addr_i = 3;
    tick();
    // WAW: issuing x3 again while pending must stall and be ignored.
    #1;
    n_checks++; if (stall_o !== 1'b1 || busy_o !== 32'h8) begin n_fail++; $display("FAIL waw_stall actual=%0h/%0h required=1/8", stall_o, busy_o); end
    issue_i = 0;
    alu_valid_i = 1; alu_addr_i = 3; alu_data_i = 32'h33;
    tick();
    alu_valid_i = 0;
    issue_i = 1; issue_addr_i = 3;
    #1;
    n_checks++; if (rf_we_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL waw_no_bypass actual=%0h/%0h required=1/1", rf_we_o, stall_o); end
    issue_i = 0;
    tick();
    n_checks++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL clr_x3 actual=%0h required=0", busy_o); end
    // x3 now idle: a write to it commits on the same edge as a fresh issue.
    alu_valid_i = 1; alu_addr_i = 3; alu_data_i = 32'h34;
    tick();
    alu_valid_i = 0;
    issue_i = 1; issue_addr_i = 3;
    #1;
    n_checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== 5'd3 || stall_o !== 1'b0) begin n_fail++; $display("FAIL collide_setup actual=%0h/%0h/%0h required=1/3/0", rf_we_o, rf_addr_o, stall_o); end
    tick();
    issue_i = 0;
    n_checks++; if (busy_o !== 32'h8) begin n_fail++; $display("FAIL set_wins actual=%0h required=8", busy_o); end
  endtask

  task automatic test_mid_reset();
    issue_i = 1; issue_addr_i = 9;
    alu_valid_i = 1; alu_addr_i = 12; alu_data_i = 32'hC;
    tick();
    idle_inputs();
    #2;
    reset_i = 0;
    #1;
    n_checks++; if (busy_o !== 32'h0 || rf_we_o !== 1'b0 || rf_wd_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset actual=%0h/%0h/%0h required=0/0/0", busy_o, rf_we_o, rf_wd_o); end
    tick();
    reset_i = 1;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_raw();
    test_collision();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
